// File: rtl/alu_pkg.sv
// Shared definitions for the wide add/subtract sequencer.
//   BYTE_W         : width of one datapath slice
//   OP_ADD/OP_SUB  : encoding of the op input
//   state_e        : sequencer state encoding
package alu_pkg;
    localparam int   BYTE_W = 8;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/byte_add_sub.sv
// Combinational 8-bit ripple-carry adder/subtractor slice.
//   a, b  : byte operands
//   sub   : 1 = invert b (subtract); the +1 comes in through cin
//   cin   : carry into bit 0
//   s     : byte sum
//   c7    : carry into bit 7 (used for signed overflow)
//   cout  : carry out of bit 7
module byte_add_sub
    import alu_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              sub,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              c7,
    output logic              cout
);
    logic [BYTE_W:0]   carry;
    logic [BYTE_W-1:0] bx;

    always_comb begin
        carry    = '0;
        bx       = '0;
        s        = '0;
        carry[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            bx[i]      = b[i] ^ sub;
            s[i]       = a[i] ^ bx[i] ^ carry[i];
            carry[i+1] = (a[i] & bx[i]) | (carry[i] & (a[i] ^ bx[i]));
        end
        c7   = carry[BYTE_W-1];
        cout = carry[BYTE_W];
    end
endmodule

// File: rtl/multibyte_addsub_seq.sv
// Wide two's-complement add/subtract, one byte per cycle, LSB first.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, accepted only when idle
//   op        : 0 = a+b, 1 = a-b
//   a, b      : operands, latched on the accepting edge
//   busy      : operation in progress
//   done      : one-cycle pulse, result and flags valid
//   result    : sum/difference
//   c_out     : carry out of top byte (subtract: 1 = no borrow)
//   overflow  : signed overflow
//   zero      : result == 0
module multibyte_addsub_seq
    import alu_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     op,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] result,
    output logic                     c_out,
    output logic                     overflow,
    output logic                     zero
);
    localparam int          W     = BYTE_W * NBYTES;
    localparam int          IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             op_q, op_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [BYTE_W-1:0] a_byte, b_byte, s_byte;
    logic              c7, byte_cout;
    logic [W-1:0]      res_nxt;

    // Single shared slice; the current byte of the latched operands is muxed in.
    assign a_byte = a_q[int'(idx_q)*BYTE_W +: BYTE_W];
    assign b_byte = b_q[int'(idx_q)*BYTE_W +: BYTE_W];

    byte_add_sub u_slice (
        .a    (a_byte),
        .b    (b_byte),
        .sub  (op_q),
        .cin  (carry_q),
        .s    (s_byte),
        .c7   (c7),
        .cout (byte_cout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        // Result with the current byte merged in, so zero sees the full new value.
        res_nxt  = result_q;
        res_nxt[int'(idx_q)*BYTE_W +: BYTE_W] = s_byte;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    idx_d   = '0;
                    carry_d = op;   // +1 of a + ~b + 1 enters as byte-0 carry-in
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d = res_nxt;
                carry_d  = byte_cout;
                if (idx_q == LAST) begin
                    c_out_d = byte_cout;
                    ovf_d   = c7 ^ byte_cout;
                    zero_d  = (res_nxt == '0);
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign result   = result_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
endmodule

// File: tb/tb_multibyte_addsub_seq.sv
module tb_multibyte_addsub_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, op;
    logic [W-1:0] a, b;
    logic         busy, done, c_out, overflow, zero;
    logic [W-1:0] result;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    multibyte_addsub_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .c_out(c_out),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference model: full-width arithmetic, independent of byte slicing.
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W:0]   f;
        logic [W-1:0] yy;
        yy  = o ? ~y : y;
        f   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, o};
        e.r = f[W-1:0];
        e.c = f[W];
        e.v = (x[W-1] == yy[W-1]) && (e.r[W-1] != x[W-1]);
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input exp_t e, input bit push);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    endtask

    // Waits (bounded) for done, counting edges and busy cycles from entry.
    task automatic wait_done(output int edges, output int busy_n);
        int n;
        n = 0; busy_n = 0;
        while (!done && n < 30) begin
            if (busy) busy_n++;
            @(negedge clk);
            n++;
        end
        edges = n;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; op = 1'b1; a = 32'h1234_5678; b = 32'h1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, result, c_out, overflow, zero} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, c_out, overflow, zero);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith;
        logic         o_t [10];
        logic [W-1:0] a_t [10], b_t [10], r_t [10];
        logic [2:0]   f_t [10];   // {c, v, z}
        exp_t e, g;
        int   edges, bn;
        o_t[0]=0; a_t[0]=32'h0000_00FF; b_t[0]=32'h0000_0001; r_t[0]=32'h0000_0100; f_t[0]=3'b000;
        o_t[1]=1; a_t[1]=32'h1234_5678; b_t[1]=32'h1234_5678; r_t[1]=32'h0000_0000; f_t[1]=3'b101;
        o_t[2]=0; a_t[2]=32'h7FFF_FFFF; b_t[2]=32'h0000_0001; r_t[2]=32'h8000_0000; f_t[2]=3'b010;
        o_t[3]=1; a_t[3]=32'h8000_0000; b_t[3]=32'h0000_0001; r_t[3]=32'h7FFF_FFFF; f_t[3]=3'b110;
        o_t[4]=1; a_t[4]=32'h0000_0000; b_t[4]=32'h0000_0001; r_t[4]=32'hFFFF_FFFF; f_t[4]=3'b000;
        o_t[5]=0; a_t[5]=32'hFFFF_FFFF; b_t[5]=32'h0000_0001; r_t[5]=32'h0000_0000; f_t[5]=3'b101;
        for (int i = 6; i < 10; i++) begin
            o_t[i] = 1'($urandom); a_t[i] = $urandom; b_t[i] = $urandom;
            e = model(o_t[i], a_t[i], b_t[i]);
            r_t[i] = e.r; f_t[i] = {e.c, e.v, e.z};
        end
        for (int i = 0; i < 10; i++) begin
            e.r = r_t[i]; {e.c, e.v, e.z} = f_t[i];
            launch(o_t[i], a_t[i], b_t[i], e, 1'b1);
            wait_done(edges, bn);
            g = sb.pop_front();
            checks++;
            if ({result, c_out, overflow, zero} !== {g.r, g.c, g.v, g.z}) begin
                errors++;
                $display("FAIL arith[%0d]: got r=%h c=%b v=%b z=%b, required r=%h c=%b v=%b z=%b",
                         i, result, c_out, overflow, zero, g.r, g.c, g.v, g.z);
            end
            checks++;
            if (edges != NB || bn != NB || busy !== 1'b0) begin
                errors++;
                $display("FAIL latency[%0d]: edges=%0d busy_cycles=%0d busy_at_done=%b, required %0d/%0d/0",
                         i, edges, bn, busy, NB, NB);
            end
        end
        // done must be a single-cycle pulse with held results
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== r_t[9]) begin
            errors++;
            $display("FAIL done_pulse: done=%b result=%h, required 0/%h", done, result, r_t[9]);
        end
    endtask

    task automatic test_busy_ignore;
        exp_t e, g;
        int   edges, bn;
        bit   extra;
        e = '{r: 32'h3333_3333, c: 1'b0, v: 1'b0, z: 1'b0};
        launch(1'b0, 32'h1111_1111, 32'h2222_2222, e, 1'b1);
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'hAAAA_AAAA; b = 32'hAAAA_AAAA;
        @(negedge clk);
        start = 1'b0;
        wait_done(edges, bn);
        g = sb.pop_front();
        checks++;
        if ({result, c_out, overflow, zero} !== {g.r, g.c, g.v, g.z}) begin
            errors++;
            $display("FAIL busy_ignore: got r=%h c=%b v=%b z=%b, required r=%h c=%b v=%b z=%b",
                     result, c_out, overflow, zero, g.r, g.c, g.v, g.z);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) extra = 1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL busy_queued: got activity after ignored start, required none");
        end
    endtask

    task automatic test_back_to_back;
        exp_t e1, e2, g;
        int   edges, bn;
        e1 = model(1'b1, 32'h0000_1000, 32'h0000_0001);
        e2 = model(1'b0, 32'hDEAD_BEEF, 32'h0101_0101);
        launch(1'b1, 32'h0000_1000, 32'h0000_0001, e1, 1'b1);
        wait_done(edges, bn);
        g = sb.pop_front();
        checks++;
        if ({result, c_out, overflow, zero} !== {g.r, g.c, g.v, g.z}) begin
            errors++;
            $display("FAIL b2b_first: got r=%h, required r=%h", result, g.r);
        end
        // start during the done cycle
        start = 1'b1; op = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0101_0101;
        sb.push_back(e2);
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; op = 1'b1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, required 1/0", busy, done);
        end
        wait_done(edges, bn);
        g = sb.pop_front();
        checks++;
        if ({result, c_out, overflow, zero} !== {g.r, g.c, g.v, g.z} || edges != NB) begin
            errors++;
            $display("FAIL b2b_second: got r=%h c=%b v=%b z=%b edges=%0d, required r=%h c=%b v=%b z=%b edges=%0d",
                     result, c_out, overflow, zero, edges, g.r, g.c, g.v, g.z, NB);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e, g;
        int   edges, bn;
        bit   seen;
        e = model(1'b0, 32'h0F0F_0F0F, 32'h0101_0101);
        launch(1'b0, 32'h0F0F_0F0F, 32'h0101_0101, e, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, result, c_out, overflow, zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, c_out, overflow, zero);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_done: got done after abort, required none");
        end
        e = model(1'b1, 32'h0000_0005, 32'h0000_0007);
        launch(1'b1, 32'h0000_0005, 32'h0000_0007, e, 1'b1);
        wait_done(edges, bn);
        g = sb.pop_front();
        checks++;
        if ({result, c_out, overflow, zero} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0} ||
            {result, c_out, overflow, zero} !== {g.r, g.c, g.v, g.z}) begin
            errors++;
            $display("FAIL after_reset: got r=%h c=%b v=%b z=%b, required r=fffffffe c=0 v=0 z=0",
                     result, c_out, overflow, zero);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        test_reset();
        test_arith();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
